// File: rtl/top_datapath_if.sv
// Flat bus bundle for top_datapath: op words in, registered results/status out.
interface top_datapath_if;
    logic [138:0] in_flat;
    logic [158:0] out_flat;

    modport master (
        output in_flat,
        input  out_flat
    );

    modport slave (
        input  in_flat,
        output out_flat
    );
endinterface

// File: rtl/top_datapath.sv
// top_datapath: registered single-issue ALU, 64-bit accumulator and rolling checksum.
// One packed op word per cycle on in_flat; every out_flat bit comes straight from a flop.
// Optional macro TOP_DATAPATH_SAT_EN: accumulator saturates at all-ones instead of wrapping.
module top_datapath (
    input  logic          clk,
    input  logic          rst_n,
    top_datapath_if.slave bus
);

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] op_c;
    logic [31:0] op_d;
    logic [2:0]  opcode;
    logic        valid;
    logic        clear;
    logic [4:0]  rot_amt;
    logic        unused_shamt_msb;

    assign op_a             = bus.in_flat[31:0];
    assign op_b             = bus.in_flat[63:32];
    assign op_c             = bus.in_flat[95:64];
    assign op_d             = bus.in_flat[127:96];
    assign opcode           = bus.in_flat[130:128];
    assign valid            = bus.in_flat[131];
    assign clear            = bus.in_flat[132];
    assign rot_amt          = bus.in_flat[137:133];
    assign unused_shamt_msb = bus.in_flat[138];

    logic [31:0] alu_res;
    logic        alu_carry;
    logic [63:0] rot_buf;
    logic [5:0]  alu_ones;
    logic [64:0] acc_sum;

    logic [63:0] acc_q,     acc_d;
    logic [31:0] result_q,  result_d;
    logic [31:0] chk_q,     chk_d;
    logic [15:0] vcount_q,  vcount_d;
    logic        carry_q,   carry_d;
    logic        zero_q,    zero_d;
    logic        ovf_q,     ovf_d;
    logic        rvalid_q,  rvalid_d;
    logic [2:0]  last_op_q, last_op_d;
    logic [5:0]  popcnt_q,  popcnt_d;

    // ALU: compute this cycle's result and carry/borrow from the decoded op word
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        rot_buf   = '0;
        case (opcode)
            3'd0: {alu_carry, alu_res} = {1'b0, op_a} + {1'b0, op_b};
            3'd1: begin
                alu_res   = op_a - op_b;
                alu_carry = (op_a < op_b);
            end
            3'd2: alu_res = op_a & op_b;
            3'd3: alu_res = op_c ^ op_d;
            3'd4: alu_res = {16'b0, op_a[15:0]} * {16'b0, op_b[15:0]};
            3'd5: begin
                // upper half of the doubled word shifted left is the left rotation
                rot_buf = {op_a, op_a} << rot_amt;
                alu_res = rot_buf[63:32];
            end
            3'd6: alu_res = (op_a < op_b) ? op_a : op_b;
            default: alu_res = (op_a < op_b) ? op_b : op_a;
        endcase
    end

    // Population count of the ALU result
    always_comb begin
        alu_ones = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            alu_ones = alu_ones + {5'b0, alu_res[i]};
        end
    end

    // Next-state: clear beats valid; an idle cycle only drops rvalid
    always_comb begin
        acc_d     = acc_q;
        result_d  = result_q;
        chk_d     = chk_q;
        vcount_d  = vcount_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        rvalid_d  = 1'b0;
        last_op_d = last_op_q;
        popcnt_d  = popcnt_q;
        acc_sum   = {1'b0, acc_q} + {33'b0, alu_res};

        if (clear) begin
            acc_d    = '0;
            ovf_d    = 1'b0;
            chk_d    = '0;
            vcount_d = '0;
        end else if (valid) begin
            result_d  = alu_res;
            last_op_d = opcode;
            rvalid_d  = 1'b1;
            vcount_d  = vcount_q + 16'd1;
            popcnt_d  = alu_ones;
            zero_d    = (alu_res == '0);
            carry_d   = alu_carry;
            chk_d     = {chk_q[30:0], chk_q[31]} ^ op_d ^ alu_res;
            if (acc_sum[64]) begin
                ovf_d = 1'b1;
`ifdef TOP_DATAPATH_SAT_EN
                acc_d = '1;
`else
                acc_d = acc_sum[63:0];
`endif
            end else begin
                acc_d = acc_sum[63:0];
            end
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q     <= '0;
            result_q  <= '0;
            chk_q     <= '0;
            vcount_q  <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            last_op_q <= '0;
            popcnt_q  <= '0;
        end else begin
            acc_q     <= acc_d;
            result_q  <= result_d;
            chk_q     <= chk_d;
            vcount_q  <= vcount_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            rvalid_q  <= rvalid_d;
            last_op_q <= last_op_d;
            popcnt_q  <= popcnt_d;
        end
    end

    assign bus.out_flat = {2'b00, popcnt_q, last_op_q, rvalid_q, ovf_q, zero_q, carry_q,
                           vcount_q, chk_q, result_q, acc_q};

endmodule

// File: tb/tb_top_datapath.sv
// Randomized self-checking bench for top_datapath against a behavioural model.
module tb_top_datapath;

    logic clk;
    logic rst_n;

    top_datapath_if bus_if ();

    top_datapath dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // model state
    logic [63:0] m_acc;
    logic [31:0] m_res;
    logic [31:0] m_chk;
    logic [15:0] m_vc;
    logic        m_carry;
    logic        m_zero;
    logic        m_ovf;
    logic        m_rvalid;
    logic [2:0]  m_lop;
    logic [5:0]  m_pop;

    task automatic check(input string tag, input logic [158:0] obs, input logic [158:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [138:0] pack(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d,
                                          input logic [2:0] op, input logic v,
                                          input logic clr, input logic [5:0] sh);
        return {sh, clr, v, op, d, c, b, a};
    endfunction

    // Reference ALU: returns {carry, result}
    function automatic logic [32:0] ref_alu(input logic [138:0] w);
        logic [31:0] a, b, c, d;
        int unsigned s;
        a = w[31:0];
        b = w[63:32];
        c = w[95:64];
        d = w[127:96];
        s = int'(w[137:133]);
        case (w[130:128])
            3'd0: return {1'b0, a} + {1'b0, b};
            3'd1: return {(a < b), a - b};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, c ^ d};
            3'd4: return {1'b0, 32'(a[15:0]) * 32'(b[15:0])};
            3'd5: return {1'b0, (a << s) | ((s == 0) ? 32'd0 : (a >> (32 - s)))};
            3'd6: return {1'b0, (a < b) ? a : b};
            default: return {1'b0, (a > b) ? a : b};
        endcase
    endfunction

    task automatic model_update(input logic rst, input logic [138:0] w);
        logic [32:0]  cr;
        logic [64:0]  sum;
        if (!rst) begin
            m_acc = '0; m_res = '0; m_chk = '0; m_vc = '0; m_carry = 0;
            m_zero = 0; m_ovf = 0; m_rvalid = 0; m_lop = '0; m_pop = '0;
        end else if (w[132]) begin
            m_acc = '0; m_ovf = 0; m_chk = '0; m_vc = '0; m_rvalid = 0;
        end else if (w[131]) begin
            cr       = ref_alu(w);
            m_chk    = {m_chk[30:0], m_chk[31]} ^ w[127:96] ^ cr[31:0];
            m_res    = cr[31:0];
            m_carry  = cr[32];
            m_zero   = (cr[31:0] == 0);
            m_pop    = 6'($countones(cr[31:0]));
            m_lop    = w[130:128];
            m_rvalid = 1;
            m_vc     = m_vc + 1;
            sum      = 65'(m_acc) + 65'(cr[31:0]);
            if (sum > 65'h0_FFFF_FFFF_FFFF_FFFF) begin
                m_ovf = 1;
`ifdef TOP_DATAPATH_SAT_EN
                m_acc = 64'hFFFF_FFFF_FFFF_FFFF;
`else
                m_acc = sum[63:0];
`endif
            end else begin
                m_acc = sum[63:0];
            end
        end else begin
            m_rvalid = 0;
        end
    endtask

    task automatic compare_all();
        logic [158:0] o;
        o = bus_if.out_flat;
        check("acc",     159'(o[63:0]),    159'(m_acc));
        check("result",  159'(o[95:64]),   159'(m_res));
        check("chk",     159'(o[127:96]),  159'(m_chk));
        check("vcount",  159'(o[143:128]), 159'(m_vc));
        check("carry",   159'(o[144]),     159'(m_carry));
        check("zero",    159'(o[145]),     159'(m_zero));
        check("acc_ovf", 159'(o[146]),     159'(m_ovf));
        check("rvalid",  159'(o[147]),     159'(m_rvalid));
        check("last_op", 159'(o[150:148]), 159'(m_lop));
        check("popcnt",  159'(o[156:151]), 159'(m_pop));
        check("pad",     159'(o[158:157]), 159'(0));
    endtask

    task automatic step(input logic rst, input logic [138:0] w);
        @(negedge clk);
        rst_n          = rst;
        bus_if.in_flat = w;
        @(posedge clk);
        model_update(rst, w);
        #1;
        compare_all();
    endtask

    function automatic logic [138:0] rand_word();
        logic [31:0] a, b;
        a = $urandom;
        b = ($urandom_range(0, 7) == 0) ? a : $urandom;
        return pack(a, b, $urandom, $urandom, 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                    6'($urandom_range(0, 63)));
    endfunction

    logic [31:0] saved_res;

    initial begin
        rst_n          = 1'b0;
        bus_if.in_flat = '0;

        // reset held two cycles with random inputs
        for (int i = 0; i < 2; i++) begin
            step(1'b0, {rand_word()});
            check("reset_out", bus_if.out_flat, '0);
        end

        // add with carry-out producing zero
        step(1'b1, pack(32'hFFFF_FFFF, 32'd1, 0, 0, 3'd0, 1, 0, 0));
        check("add_res",    159'(bus_if.out_flat[95:64]),   159'(0));
        check("add_carry",  159'(bus_if.out_flat[144]),     159'(1));
        check("add_zero",   159'(bus_if.out_flat[145]),     159'(1));
        check("add_pop",    159'(bus_if.out_flat[156:151]), 159'(0));
        check("add_acc",    159'(bus_if.out_flat[63:0]),    159'(0));
        check("add_vcount", 159'(bus_if.out_flat[143:128]), 159'(1));
        check("add_rvalid", 159'(bus_if.out_flat[147]),     159'(1));

        step(1'b1, pack(32'h0001_8000, 32'h0000_0002, 0, 0, 3'd4, 1, 0, 0));
        check("mul_res", 159'(bus_if.out_flat[95:64]), 159'(32'h0001_0000));
        step(1'b1, pack(32'h8000_0001, 0, 0, 0, 3'd5, 1, 0, 6'h21));
        check("rotl_res", 159'(bus_if.out_flat[95:64]), 159'(32'h0000_0003));
        step(1'b1, pack(32'h1234_5678, 0, 0, 0, 3'd5, 1, 0, 6'h20));
        check("rotl0_res", 159'(bus_if.out_flat[95:64]), 159'(32'h1234_5678));
        step(1'b1, pack(32'd5, 32'd9, 0, 0, 3'd6, 1, 0, 0));
        check("min_res", 159'(bus_if.out_flat[95:64]), 159'(5));
        step(1'b1, pack(32'd5, 32'd9, 0, 0, 3'd7, 1, 0, 0));
        check("max_res", 159'(bus_if.out_flat[95:64]), 159'(9));
        step(1'b1, pack(0, 0, 32'hF0F0_F0F0, 32'hFFFF_0000, 3'd3, 1, 0, 0));
        check("xor_res", 159'(bus_if.out_flat[95:64]), 159'(32'h0F0F_F0F0));
        step(1'b1, pack(32'd3, 32'd7, 0, 0, 3'd1, 1, 0, 0));
        check("sub_borrow", 159'(bus_if.out_flat[144]), 159'(1));

        // clear beats valid
        saved_res = bus_if.out_flat[95:64];
        step(1'b1, pack(32'hAAAA_5555, 32'h1, 0, 32'h77, 3'd0, 1, 1, 0));
        check("clr_acc",    159'(bus_if.out_flat[63:0]),    159'(0));
        check("clr_chk",    159'(bus_if.out_flat[127:96]),  159'(0));
        check("clr_vcount", 159'(bus_if.out_flat[143:128]), 159'(0));
        check("clr_rvalid", 159'(bus_if.out_flat[147]),     159'(0));
        check("clr_result", 159'(bus_if.out_flat[95:64]),   159'(saved_res));

        // random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) != 0), rand_word());
        end

        // vcount wrap after 65536 counted ops
        step(1'b1, pack(0, 0, 0, 0, 3'd0, 0, 1, 0));
        for (int i = 0; i < 65535; i++) begin
            step(1'b1, pack($urandom, $urandom, $urandom, $urandom,
                            3'($urandom_range(0, 7)), 1, 0, 6'($urandom_range(0, 63))));
        end
        check("vcount_max", 159'(bus_if.out_flat[143:128]), 159'(16'hFFFF));
        step(1'b1, pack(32'd1, 32'd2, 0, 0, 3'd0, 1, 0, 0));
        check("vcount_wrap", 159'(bus_if.out_flat[143:128]), 159'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
